matrix_alu_sequencer: RTL

//  Upstream controller for the 4x4 matrix ALU. On start it reads two 16-element matrices

---
 rtl/matrix_alu_pkg.sv | 41 ++++
 rtl/matrix_word_packer.sv | 29 ++
 rtl/matrix_alu_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_alu_pkg.sv
// Shared definitions for the 4x4 matrix ALU, its upstream sequencer and benches.
//   ELEM_W/N_ELEM/MAT_W : element and packed-matrix geometry
//   OP_*                : ALU opcodes (OP_NOP idles the ALU)
//   seq_state_e         : sequencer FSM encoding
package matrix_alu_pkg;

  localparam int unsigned ELEM_W = 16;
  localparam int unsigned N_ELEM = 16;
  localparam int unsigned MAT_W  = ELEM_W * N_ELEM;
  localparam int unsigned IDX_W  = $clog2(N_ELEM);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_SCALE = 3'b011;
  localparam logic [2:0] OP_TRANS = 3'b100;
  localparam logic [2:0] OP_MULTI = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD1,
    ST_WAIT_L1,
    ST_RD2,
    ST_WAIT_L2,
    ST_EXEC,
    ST_WR,
    ST_DONE
  } seq_state_e;

  // True for opcodes the ALU implements.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_MULTI);
  endfunction

  // Element i of a packed row-major matrix (row r, col c -> i = 4r + c).
  function automatic logic [ELEM_W-1:0] mat_elem(input logic [MAT_W-1:0] m,
                                                  input logic [IDX_W-1:0] i);
    return m[i*ELEM_W +: ELEM_W];
  endfunction

endpackage

// File: rtl/matrix_word_packer.sv
// 16 x 16-bit element register presented as one packed 256-bit matrix.
//   clk, reset : clock, synchronous active-high reset
//   wr_en      : write wr_data into element wr_idx
//   load_en    : load the whole matrix from load_mat (wins over wr_en)
//   mat        : registered packed matrix, element i at bits [16i+15:16i]
module matrix_word_packer
  import matrix_alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ELEM_W-1:0] wr_data,
  input  logic              load_en,
  input  logic [MAT_W-1:0]  load_mat,
  output logic [MAT_W-1:0]  mat
);

  always_ff @(posedge clk) begin
    if (reset) begin
      mat <= '0;
    end else if (load_en) begin
      mat <= load_mat;
    end else if (wr_en) begin
      mat[wr_idx*ELEM_W +: ELEM_W] <= wr_data;
    end
  end

endmodule

// File: rtl/matrix_alu_sequencer.sv
// Upstream controller for the 4x4 matrix ALU: reads two matrices from word memory,
// loads them into the ALU, runs the opcode and writes the 16 result words back.
//   clk, reset                 : clock, synchronous active-high reset
//   start, op_code, src1_addr,
//   src2_addr, dst_addr, scalar: command, sampled only in IDLE
//   busy, done, error          : status (done/error are one-cycle pulses)
//   mem_*                      : word memory port, read data one cycle after mem_rd
//   alu_*                      : ALU load handshakes, opcode/scalar, result capture
// ELEM_W and N_ELEM are fixed by matrix_alu_pkg.
module matrix_alu_sequencer
  import matrix_alu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op_code,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic [ADDR_W-1:0] src2_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [7:0]        scalar,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [ELEM_W-1:0] mem_rdata,
  output logic              mem_wr,
  output logic [ELEM_W-1:0] mem_wdata,
  output logic [MAT_W-1:0]  alu_mat_in,
  output logic              alu_load_m1,
  output logic              alu_load_m2,
  input  logic              alu_load1,
  input  logic              alu_load2,
  output logic [2:0]        alu_op_code,
  output logic [7:0]        alu_source2,
  input  logic [MAT_W-1:0]  alu_mat_out,
  input  logic              alu_finish
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned RDC_W = IDX_W + 1;

  seq_state_e        state_q, state_d;
  logic [RDC_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] src1_q, src2_q, dst_q;
  logic [7:0]        scalar_q;

  logic              latch_cmd, timeout_hit, error_d;
  logic              in_wr_en, res_load;
  logic [IDX_W-1:0]  in_wr_idx;
  logic [MAT_W-1:0]  res_mat;

  logic              busy_d, done_d, mem_rd_d, mem_wr_d, load_m1_d, load_m2_d;
  logic [ADDR_W-1:0] base, mem_addr_d;
  logic [ELEM_W-1:0] mem_wdata_d;
  logic [2:0]        op_d;
  logic [7:0]        source2_d;

  // Input matrix: read word i-1 lands while read i is issued.
  matrix_word_packer u_in_pack (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (in_wr_en),
    .wr_idx   (in_wr_idx),
    .wr_data  (mem_rdata),
    .load_en  (1'b0),
    .load_mat ('0),
    .mat      (alu_mat_in)
  );

  // Result matrix, captured on alu_finish and unpacked during WR.
  matrix_word_packer u_res_pack (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (1'b0),
    .wr_idx   ('0),
    .wr_data  ('0),
    .load_en  (res_load),
    .load_mat (alu_mat_out),
    .mat      (res_mat)
  );

  // Next-state, counters and datapath strobes.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    latch_cmd   = 1'b0;
    error_d     = 1'b0;
    in_wr_en    = 1'b0;
    in_wr_idx   = IDX_W'(idx_q - RDC_W'(1));
    res_load    = 1'b0;
    timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (start) begin
          latch_cmd = 1'b1;
          if (op_is_legal(op_code)) state_d = ST_RD1;
          else                      error_d = 1'b1;
        end
      end
      // N_ELEM read cycles plus one to capture the last word.
      ST_RD1, ST_RD2: begin
        in_wr_en = (idx_q != '0);
        if (idx_q == RDC_W'(N_ELEM)) begin
          state_d = (state_q == ST_RD1) ? ST_WAIT_L1 : ST_WAIT_L2;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          idx_d = idx_q + RDC_W'(1);
        end
      end
      ST_WAIT_L1: begin
        if (alu_load1) begin
          state_d = ST_RD2;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_L2: begin
        if (alu_load2) begin
          state_d = ST_EXEC;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EXEC: begin
        if (alu_finish) begin
          res_load = 1'b1;
          state_d  = ST_WR;
          idx_d    = '0;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR: begin
        if (idx_q == RDC_W'(N_ELEM - 1)) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + RDC_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the cycle being entered, so every output comes from a flop.
  always_comb begin
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    mem_rd_d  = ((state_d == ST_RD1) || (state_d == ST_RD2)) && (idx_d < RDC_W'(N_ELEM));
    mem_wr_d  = (state_d == ST_WR);
    load_m1_d = (state_d == ST_WAIT_L1);
    load_m2_d = (state_d == ST_WAIT_L2);
    op_d      = (state_d == ST_EXEC) ? op_q : OP_NOP;
    source2_d = (state_d == ST_EXEC) ? scalar_q : 8'd0;

    // Command registers are loaded on the same edge that enters RD1.
    case (state_d)
      ST_RD1:  base = (state_q == ST_IDLE) ? src1_addr : src1_q;
      ST_RD2:  base = src2_q;
      ST_WR:   base = dst_q;
      default: base = '0;
    endcase
    mem_addr_d = (mem_rd_d || mem_wr_d) ? ADDR_W'(base + ADDR_W'(idx_d[IDX_W-1:0])) : '0;

    // The first write coincides with result capture, so take it straight from the ALU.
    mem_wdata_d = '0;
    if (mem_wr_d) begin
      mem_wdata_d = (state_q == ST_EXEC) ? mat_elem(alu_mat_out, IDX_W'(0))
                                         : mat_elem(res_mat, idx_d[IDX_W-1:0]);
    end
  end

  // State, counters, command and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      op_q        <= OP_NOP;
      src1_q      <= '0;
      src2_q      <= '0;
      dst_q       <= '0;
      scalar_q    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_wdata   <= '0;
      alu_load_m1 <= 1'b0;
      alu_load_m2 <= 1'b0;
      alu_op_code <= OP_NOP;
      alu_source2 <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      if (latch_cmd) begin
        op_q     <= op_code;
        src1_q   <= src1_addr;
        src2_q   <= src2_addr;
        dst_q    <= dst_addr;
        scalar_q <= scalar;
      end
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
      mem_addr    <= mem_addr_d;
      mem_rd      <= mem_rd_d;
      mem_wr      <= mem_wr_d;
      mem_wdata   <= mem_wdata_d;
      alu_load_m1 <= load_m1_d;
      alu_load_m2 <= load_m2_d;
      alu_op_code <= op_d;
      alu_source2 <= source2_d;
    end
  end

endmodule
